// File: rtl/sine_filter_pkg.sv
// sine_filter shared types, coefficients and output scaling.
// Coefficients are a half-sine window normalised to unity DC gain.
package sine_filter_pkg;

    localparam int DW    = 18;
    localparam int CW    = 18;
    localparam int NTAPS = 11;
    localparam int ACC_W = 40;
    localparam int FRAC  = 17;

    typedef logic signed [DW-1:0] sample_t;
    typedef logic [CW-1:0]        coef_t;

    localparam coef_t COEF [NTAPS] = '{
        18'd4466,  18'd8628,  18'd12202, 18'd14944,
        18'd16668, 18'd17256, 18'd16668, 18'd14944,
        18'd12202, 18'd8628,  18'd4466
    };

    localparam logic signed [ACC_W-1:0] SMAX = 131071;
    localparam logic signed [ACC_W-1:0] SMIN = -131072;

    // Floor scaling (arithmetic shift) then clamp to the 1s17 range.
    function automatic sample_t sat_shift(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0] s;
        s = acc >>> FRAC;
        if (s > SMAX)
            s = SMAX;
        else if (s < SMIN)
            s = SMIN;
        return s[DW-1:0];
    endfunction

endpackage

// File: rtl/sine_filter_mac.sv
// Folded tap: pre-add a symmetric sample pair, scale by a constant
// coefficient and sign-extend to the accumulator width.
module sine_filter_mac
    import sine_filter_pkg::*;
#(
    parameter coef_t C      = '0,
    parameter bit    CENTER = 1'b0
) (
    input  logic [DW-1:0]            a,
    input  logic [DW-1:0]            b,
    output logic signed [ACC_W-1:0]  p
);

    logic signed [DW:0]   pre;
    logic signed [37:0]   pre_x;
    logic signed [37:0]   coef_x;
    logic signed [37:0]   prod;

    always_comb begin
        pre = CENTER ? $signed({a[DW-1], a})
                     : $signed({a[DW-1], a}) + $signed({b[DW-1], b});
    end

    assign pre_x  = pre;
    assign coef_x = $signed({20'd0, C});
    assign prod   = pre_x * coef_x;
    assign p      = {{(ACC_W-38){prod[37]}}, prod};

endmodule

// File: rtl/sine_filter.sv
// sine_filter: 11-tap symmetric half-sine FIR low-pass, one sample
// per clock in and out, registered output.
module sine_filter
    import sine_filter_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] x_in,
    output logic [DW-1:0] y
);

    sample_t x_q [NTAPS];
    sample_t x_d [NTAPS];
    sample_t y_q;
    sample_t y_d;

    logic signed [ACC_W-1:0] p [6];
    logic signed [ACC_W-1:0] acc;

    for (genvar k = 0; k < 5; k++) begin : g_pair
        sine_filter_mac #(
            .C      (COEF[k]),
            .CENTER (1'b0)
        ) u_mac (
            .a (x_q[k]),
            .b (x_q[NTAPS-1-k]),
            .p (p[k])
        );
    end

    sine_filter_mac #(
        .C      (COEF[5]),
        .CENTER (1'b1)
    ) u_mac_ctr (
        .a (x_q[5]),
        .b (x_q[5]),
        .p (p[5])
    );

    always_comb begin
        x_d[0] = x_in;
        for (int k = 1; k < NTAPS; k++)
            x_d[k] = x_q[k-1];
        acc = p[0] + p[1] + p[2] + p[3] + p[4] + p[5];
        y_d = sat_shift(acc);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAPS; k++)
                x_q[k] <= '0;
            y_q <= '0;
        end else begin
            for (int k = 0; k < NTAPS; k++)
                x_q[k] <= x_d[k];
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_sine_filter.sv
// Self-checking bench for sine_filter: vector tables, corner sequences
// and random samples against a convolution reference model.
module tb_sine_filter;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] x_in;
    logic [17:0] y;

    always #5 clk = ~clk;

    sine_filter dut (
        .clk   (clk),
        .reset (reset),
        .x_in  (x_in),
        .y     (y)
    );

    int n_cmp = 0;
    int n_err = 0;

    int h [11] = '{4466, 8628, 12202, 14944, 16668, 17256,
                   16668, 14944, 12202, 8628, 4466};
    int hist [11];
    int y_exp;

    typedef struct {
        int x;
        int ey;
    } vec_t;

    vec_t vecs [$];

    function automatic int ref_y();
        longint s;
        longint q;
        s = 0;
        for (int k = 0; k < 11; k++)
            s += longint'(h[k]) * longint'(hist[k]);
        q = s / 131072;
        if (s < 0 && q * 131072 != s)
            q = q - 1;
        if (q > 131071)
            q = 131071;
        if (q < -131072)
            q = -131072;
        return int'(q);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 11; k++)
            hist[k] = 0;
        y_exp = 0;
    endtask

    // Apply one sample, advance one edge, update model, compare to model.
    task automatic step(input int x);
        x_in = 18'(x);
        @(posedge clk);
        #1;
        y_exp = ref_y();
        for (int k = 10; k > 0; k--)
            hist[k] = hist[k-1];
        hist[0] = x;
        check("model", $signed(y), y_exp);
    endtask

    task automatic run_table(input string nm);
        foreach (vecs[i]) begin
            step(vecs[i].x);
            check(nm, $signed(y), vecs[i].ey);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic hold(input int x, input int n, input string nm);
        repeat (n) step(x);
        check(nm, $signed(y), x);
    endtask

    task automatic load_ramp();
        int r [7] = '{0, 2233, 6547, 12648, 20120, 28454, 37082};
        vecs.delete();
        foreach (r[i])
            vecs.push_back('{65536, r[i]});
    endtask

    initial begin
        int imp [13] = '{0, 2233, 4314, 6101, 7472, 8334, 8628,
                         8334, 7472, 6101, 4314, 2233, 0};

        reset = 1'b0;
        x_in  = '0;
        model_reset();
        #3;
        check("reset_async", $signed(y), 0);

        repeat (21) begin
            @(negedge clk);
            x_in = 18'($urandom);
            @(posedge clk);
            #1;
            check("reset_hold", $signed(y), 0);
        end
        @(negedge clk);
        x_in  = '0;
        reset = 1'b1;
        repeat (4) begin
            step(0);
            check("post_reset_zero", $signed(y), 0);
        end

        // Impulse of 0.5
        vecs.delete();
        foreach (imp[i])
            vecs.push_back('{(i == 0) ? 65536 : 0, imp[i]});
        run_table("impulse");

        // Step ramp and settle
        do_reset();
        load_ramp();
        run_table("ramp");
        hold(65536, 8, "settle_pos");
        step(65536);
        check("settle_pos_hold", $signed(y), 65536);

        // Asynchronous mid-stream reset pulse
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset", $signed(y), 0);
        reset = 1'b1;
        model_reset();
        load_ramp();
        run_table("ramp_after_reset");

        do_reset();
        hold(-65536, 14, "settle_neg");
        do_reset();
        hold(131071, 14, "full_pos");
        do_reset();
        hold(-131072, 14, "full_neg");
        hold(131071, 14, "full_swing_up");
        hold(-131072, 14, "full_swing_down");

        // Floor rounding
        do_reset();
        step(131071);
        step(0);
        check("floor_max_first", $signed(y), 4465);
        repeat (12) step(0);
        do_reset();
        step(-1);
        for (int i = 0; i < 11; i++) begin
            step(0);
            check("floor_neg1", $signed(y), -1);
        end
        step(0);
        check("floor_neg1_end", $signed(y), 0);

        // Random samples, including full-scale bursts
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(9) == 0)
                step($urandom_range(1) ? 131071 : -131072);
            else
                step(int'($signed(18'($urandom))));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
